// File: rtl/at_pkg.sv
`default_nettype none
// ============================================================================
// Module   : at_pkg
// Purpose  : Shared widths, word type and scheduler state encoding for the
//            Adder_tree scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package at_pkg;

    localparam int NUM_IN  = 64;
    localparam int NUM_OUT = 8;
    localparam int DATA_W  = 32;

    typedef logic [DATA_W-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2,
        GAP  = 2'd3
    } sched_state_t;

endpackage : at_pkg
`default_nettype wire

// File: rtl/adder_tree_sched_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin pick. Searches req starting at ptr and
//            wrapping; returns a one-hot grant and its index. The pointer
//            register is owned by the caller.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    logic found;
    int   k;

    // First requester at or after ptr (modulo N) wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        k       = 0;
        for (int i = 0; i < N; i++) begin
            k = (int'(ptr) + i) % N;
            if (!found && req[k]) begin
                found   = 1'b1;
                gnt[k]  = 1'b1;
                gnt_idx = IW'(k);
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/adder_tree_sched.sv
`default_nettype none
// ============================================================================
// Module   : adder_tree_sched
// Purpose  : Shares one Adder_tree (64 x 32b in, 8 x 32b out) between
//            NUM_REQ requesters. Round-robin grant, operand latch, tree
//            en/valid sequencing with timeout abort, tagged response channel.
// Revision : 1.0 - initial release
// ============================================================================
module adder_tree_sched
    import at_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int TIMEOUT = 255,
    localparam int IW      = $clog2(NUM_REQ),
    localparam int CW      = $clog2(TIMEOUT + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_valid,
    output logic [NUM_REQ-1:0] req_ready,
    input  word_t              req_data [NUM_REQ][NUM_IN],
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [IW-1:0]      rsp_id,
    output word_t              rsp_data [NUM_OUT],
    output logic               rsp_err,
    output logic               at_en,
    output word_t              at_data_in [NUM_IN],
    input  word_t              at_data_out [NUM_OUT],
    input  logic               at_valid,
    output logic               busy
);

    // Last RUN cycle index before the operation is declared timed out.
    localparam logic [CW-1:0] C_TMO_LAST = CW'(TIMEOUT - 1);
    localparam logic [IW-1:0] C_PTR_MAX  = IW'(NUM_REQ - 1);

    sched_state_t       r_state;
    logic [IW-1:0]      r_ptr;
    logic [CW-1:0]      r_cnt;
    logic [NUM_REQ-1:0] w_gnt;
    logic [IW-1:0]      w_gnt_idx;
    logic [IW-1:0]      w_ptr_next;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_arb (
        .req     (req_valid),
        .ptr     (r_ptr),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx)
    );

    // Grant is only offered while idle; reset forces it low immediately.
    assign req_ready  = (!rst && r_state == IDLE) ? w_gnt : '0;
    assign busy       = (r_state != IDLE);
    assign w_ptr_next = (w_gnt_idx == C_PTR_MAX) ? '0 : w_gnt_idx + 1'b1;

    // Scheduler FSM with operand, timeout counter and response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_cnt      <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_data   <= '{default: '0};
            rsp_err    <= 1'b0;
            at_en      <= 1'b0;
            at_data_in <= '{default: '0};
        end else begin
            case (r_state)
                IDLE: begin
                    if (|req_valid) begin
                        at_data_in <= req_data[w_gnt_idx];
                        rsp_id     <= w_gnt_idx;
                        r_ptr      <= w_ptr_next;
                        r_cnt      <= '0;
                        at_en      <= 1'b1;
                        r_state    <= RUN;
                    end
                end
                RUN: begin
                    r_cnt <= r_cnt + 1'b1;
                    // A valid on the final cycle still counts as success.
                    if (at_valid) begin
                        rsp_data  <= at_data_out;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        at_en     <= 1'b0;
                        r_state   <= RESP;
                    end else if (r_cnt == C_TMO_LAST) begin
                        rsp_data  <= '{default: '0};
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        at_en     <= 1'b0;
                        r_state   <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        r_state   <= GAP;
                    end
                end
                GAP: begin
                    // One idle cycle with at_en low lets the tree clear itself.
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule : adder_tree_sched
`default_nettype wire

// File: tb/tb_adder_tree_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_adder_tree_sched
// Purpose  : Self-checking bench for adder_tree_sched with a latency-3
//            behavioural Adder_tree and a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adder_tree_sched;
    import at_pkg::*;

    localparam int NR  = 4;
    localparam int TMO = 16;
    localparam int L   = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [NR-1:0] req_valid;
    logic [NR-1:0] req_ready;
    word_t         req_data [NR][NUM_IN];
    logic          rsp_valid;
    logic          rsp_ready;
    logic [1:0]    rsp_id;
    word_t         rsp_data [NUM_OUT];
    logic          rsp_err;
    logic          at_en;
    word_t         at_data_in [NUM_IN];
    word_t         at_data_out [NUM_OUT];
    logic          at_valid;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;

    adder_tree_sched #(
        .NUM_REQ (NR),
        .TIMEOUT (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_data    (req_data),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_data    (rsp_data),
        .rsp_err     (rsp_err),
        .at_en       (at_en),
        .at_data_in  (at_data_in),
        .at_data_out (at_data_out),
        .at_valid    (at_valid),
        .busy        (busy)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic word_t lane_sum(input word_t v [NUM_IN], input int o);
        word_t s = '0;
        for (int j = 0; j < 8; j++) s = s + v[8*o + j];
        return s;
    endfunction

    function automatic int pick(input int p, input logic [NR-1:0] v);
        for (int i = 0; i < NR; i++)
            if (v[(p + i) % NR]) return (p + i) % NR;
        return -1;
    endfunction

    // ---------------- Behavioural Adder_tree, latency L ----------------
    int   en_cnt = 0;
    logic tree_dead;

    // Count consecutive enabled cycles of the tree.
    always @(posedge clk) en_cnt <= at_en ? en_cnt + 1 : 0;

    // Tree outputs: done on the L-th enabled cycle, sums of groups of 8.
    always_comb begin
        at_valid = at_en && !tree_dead && (en_cnt == L - 1);
        for (int o = 0; o < NUM_OUT; o++) at_data_out[o] = lane_sum(at_data_in, o);
    end

    // ---------------- Transaction-level reference model ----------------
    typedef struct {
        int    id;
        word_t d [NUM_OUT];
        logic  err;
    } exp_t;

    exp_t  q [$];
    int    grant_log [$];
    int    mptr = 0;
    bit    m_busy = 0;
    bit    m_gap = 0;
    bit    prev_hold = 0;
    int    prev_id = 0;
    logic  prev_err = 0;
    word_t prev_d [NUM_OUT];
    int    en_len = 0;
    int    last_en_len = 0;

    // Per-cycle compare of DUT outputs against the reference model.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_req_ready", req_ready, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_at_en", at_en, 0);
            chk("rst_busy", busy, 0);
            chk("rst_rsp_id", rsp_id, 0);
            chk("rst_rsp_err", rsp_err, 0);
            chk("rst_rsp_data0", rsp_data[0], 0);
            chk("rst_at_data_in0", at_data_in[0], 0);
            q.delete();
            mptr = 0; m_busy = 0; m_gap = 0; prev_hold = 0; en_len = 0;
        end else begin
            chk("busy", busy, m_busy);
            chk("en_rsp_excl", at_en && rsp_valid, 0);
            if (m_gap) chk("gap_at_en", at_en, 0);
            if (!m_busy && |req_valid) begin
                automatic int e = pick(mptr, req_valid);
                automatic exp_t x;
                chk("req_ready_grant", req_ready, 32'(1) << e);
                x.id  = e;
                x.err = tree_dead;
                for (int o = 0; o < NUM_OUT; o++)
                    x.d[o] = tree_dead ? '0 : lane_sum(req_data[e], o);
                q.push_back(x);
                grant_log.push_back(e);
                mptr   = (e + 1) % NR;
                m_busy = 1;
            end else begin
                chk("req_ready_none", req_ready, 0);
            end
            if (prev_hold) begin
                chk("hold_rsp_valid", rsp_valid, 1);
                chk("hold_rsp_id", rsp_id, prev_id);
                chk("hold_rsp_err", rsp_err, prev_err);
                for (int o = 0; o < NUM_OUT; o++)
                    chk($sformatf("hold_rsp_data%0d", o), rsp_data[o], prev_d[o]);
            end
            prev_hold = rsp_valid && !rsp_ready;
            prev_id   = rsp_id;
            prev_err  = rsp_err;
            prev_d    = rsp_data;
            if (rsp_valid) begin
                if (q.size() == 0) begin
                    chk("rsp_unexpected", 1, 0);
                end else if (rsp_ready) begin
                    automatic exp_t x = q.pop_front();
                    chk("rsp_id", rsp_id, x.id);
                    chk("rsp_err", rsp_err, x.err);
                    for (int o = 0; o < NUM_OUT; o++)
                        chk($sformatf("rsp_data%0d", o), rsp_data[o], x.d[o]);
                end
            end
            if (m_gap) begin
                m_gap  = 0;
                m_busy = 0;
            end else if (rsp_valid && rsp_ready) begin
                m_gap = 1;
            end
            if (at_en) en_len++;
            else if (en_len > 0) begin
                last_en_len = en_len;
                en_len      = 0;
            end
        end
    end

    // ---------------- Stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int id, input word_t base, input word_t step);
        for (int k = 0; k < NUM_IN; k++) req_data[id][k] = base + word_t'(k) * step;
    endtask

    task automatic wait_grant(input int id);
        bit ok = 0;
        for (int c = 0; c < 100 && !ok; c++) begin
            @(negedge clk);
            ok = req_ready[id] && req_valid[id];
        end
        chk($sformatf("grant_wait%0d", id), ok, 1);
        tick();
    endtask

    task automatic wait_rsp();
        bit ok = 0;
        for (int c = 0; c < 100 && !ok; c++) begin
            @(negedge clk);
            ok = rsp_valid && rsp_ready;
        end
        chk("rsp_wait", ok, 1);
    endtask

    // Watchdog: never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- Directed test sequence ----------------
    initial begin
        int order [5];
        int gl0;
        bit ok;
        order = '{0, 1, 2, 3, 0};
        rst = 1; req_valid = '0; rsp_ready = 0; tree_dead = 0;
        for (int i = 0; i < NR; i++) fill(i, 0, 0);
        repeat (3) tick();
        rst = 0;
        tick();

        // Single request, all-ones operands.
        fill(0, 1, 0);
        req_valid[0] = 1; rsp_ready = 1;
        wait_grant(0);
        req_valid[0] = 0;
        wait_rsp();
        chk("single_lane0", rsp_data[0], 8);
        chk("single_lane7", rsp_data[7], 8);
        chk("single_id", rsp_id, 0);
        chk("single_err", rsp_err, 0);
        repeat (3) tick();
        chk("single_en_len", last_en_len, L);

        // Reset pulse so arbitration restarts at requester 0.
        rst = 1; tick(); tick(); rst = 0; tick();

        // Fairness with all requesters held valid.
        grant_log.delete();
        for (int i = 0; i < NR; i++) fill(i, word_t'(i * 100), 1);
        req_valid = '1;
        for (int c = 0; c < 300 && grant_log.size() < 5; c++) @(negedge clk);
        tick();
        req_valid = '0;
        for (int c = 0; c < 50 && busy; c++) @(negedge clk);
        chk("fair_count", grant_log.size(), 5);
        for (int i = 0; i < 5 && i < grant_log.size(); i++)
            chk($sformatf("fair_order%0d", i), grant_log[i], order[i]);
        tick();

        // Back-pressure: response held 10 cycles, no new grant meanwhile.
        rsp_ready = 0;
        fill(1, 100, 1);
        fill(2, 5, 2);
        req_valid = 4'b0110;
        wait_grant(1);
        req_valid[1] = 0;
        ok = 0;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge clk);
            ok = rsp_valid;
        end
        chk("bp_rsp_seen", ok, 1);
        gl0 = grant_log.size();
        repeat (10) @(negedge clk);
        chk("bp_valid_held", rsp_valid, 1);
        chk("bp_lane0", rsp_data[0], 828);
        chk("bp_lane7", rsp_data[7], 1276);
        chk("bp_id", rsp_id, 1);
        chk("bp_no_grant", grant_log.size(), gl0);
        @(posedge clk); #1;
        rsp_ready = 1;
        wait_grant(2);
        req_valid[2] = 0;
        wait_rsp();
        tick();

        // Timeout: tree never answers.
        tree_dead = 1;
        fill(3, 1, 0);
        req_valid[3] = 1;
        wait_grant(3);
        req_valid[3] = 0;
        wait_rsp();
        chk("tmo_err", rsp_err, 1);
        chk("tmo_lane0", rsp_data[0], 0);
        chk("tmo_lane5", rsp_data[5], 0);
        chk("tmo_id", rsp_id, 3);
        tick();
        tree_dead = 0;
        tick();
        chk("tmo_en_len", last_en_len, TMO);
        fill(0, 2, 0);
        req_valid[0] = 1;
        wait_grant(0);
        req_valid[0] = 0;
        wait_rsp();
        chk("post_tmo_lane3", rsp_data[3], 16);
        chk("post_tmo_err", rsp_err, 0);
        tick();

        // Wrap-around of 32-bit sums.
        fill(1, 32'hFFFF_FFFF, 0);
        req_valid[1] = 1;
        wait_grant(1);
        req_valid[1] = 0;
        wait_rsp();
        chk("wrap_lane0", rsp_data[0], 32'hFFFF_FFF8);
        chk("wrap_lane6", rsp_data[6], 32'hFFFF_FFF8);
        tick();

        // Reset two cycles into RUN, then the retry completes.
        fill(2, 3, 0);
        req_valid[2] = 1;
        wait_grant(2);
        tick();
        rst = 1;
        @(negedge clk);
        chk("rstrun_at_en", at_en, 0);
        chk("rstrun_busy", busy, 0);
        chk("rstrun_rsp_valid", rsp_valid, 0);
        tick();
        rst = 0;
        wait_grant(2);
        req_valid[2] = 0;
        wait_rsp();
        chk("retry_lane0", rsp_data[0], 24);
        chk("retry_id", rsp_id, 2);
        repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_adder_tree_sched
`default_nettype wire
